// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave: 8-bit command then one 8-bit data byte per frame.
// Define SPI_CMD_SLAVE_STATUS_EN to add a frame counter and the 0x04 STATUS read.
module spi_cmd_slave #(
  parameter logic [7:0] MEM_INIT    = 8'b11001000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] mem_q,
  input  logic       host_wr,
  input  logic [7:0] host_wdata,
  output logic       host_busy,
  output logic       frame_done,
  output logic [7:0] cmd_q
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_s;
  logic [SYNC_STAGES-1:0] cs_s;
  logic [SYNC_STAGES-1:0] mosi_s;
  logic                   sclk_d;
  logic                   cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s[SYNC_STAGES-1];
      cs_d   <= cs_s[SYNC_STAGES-1];
    end
  end

  logic sclk_y;
  logic cs_y;
  logic mosi_y;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;

  assign sclk_y    = sclk_s[SYNC_STAGES-1];
  assign cs_y      = cs_s[SYNC_STAGES-1];
  assign mosi_y    = mosi_s[SYNC_STAGES-1];
  assign sclk_rise = sclk_y & ~sclk_d;
  assign sclk_fall = ~sclk_y & sclk_d;
  assign cs_fall   = ~cs_y & cs_d;
  assign host_busy = ~cs_y;

  state_t     state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [7:0] cmd_sr, cmd_sr_d;
  logic [7:0] rx_sr, rx_d;
  logic [7:0] tx_sr, tx_d;
  logic [7:0] mem_d, cmdq_d;
  logic       miso_d, oe_d;
  logic       wr, wr_d;
  logic       start, start_d;
  logic       done_pend, done_d;

  logic [7:0] cmd_nx;
  logic [7:0] rx_nx;
  logic       is_read;
  logic       is_write;
  logic       is_swap;
  logic       is_stat;

  assign cmd_nx   = {cmd_sr[6:0], mosi_y};
  assign rx_nx    = {rx_sr[6:0], mosi_y};
  assign is_read  = (cmd_nx == 8'h01);
  assign is_write = (cmd_nx == 8'h02);
  assign is_swap  = (cmd_nx == 8'h03);

`ifdef SPI_CMD_SLAVE_STATUS_EN
  logic [7:0] fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fcnt <= '0;
    else if (frame_done) fcnt <= fcnt + 8'd1;
  end

  assign is_stat = (cmd_nx == 8'h04);
`else
  assign is_stat = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cmd_sr_d = cmd_sr;
    rx_d     = rx_sr;
    tx_d     = tx_sr;
    mem_d    = mem_q;
    cmdq_d   = cmd_q;
    miso_d   = miso;
    oe_d     = miso_oe;
    wr_d     = wr;
    done_d   = 1'b0;
    start_d  = (start | cs_fall) & ~cs_y;
    if (cs_y && state != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (host_wr) begin
            mem_d = host_wdata;
          end else if (start) begin
            state_d = CMD;
            cnt_d   = '0;
            start_d = 1'b0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_sr_d = cmd_nx;
            cnt_d    = cnt + 3'd1;
            if (cnt == 3'd7) begin
              cmdq_d  = cmd_nx;
              rx_d    = '0;
              tx_d    = '0;
              wr_d    = 1'b0;
              state_d = DATA;
              oe_d    = 1'b1;
              miso_d  = 1'b0;
              unique case (1'b1)
                is_read: begin
                  tx_d   = mem_q;
                  miso_d = mem_q[7];
                end
                is_write: wr_d = 1'b1;
                is_swap: begin
                  tx_d   = mem_q;
                  miso_d = mem_q[7];
                  wr_d   = 1'b1;
                end
                is_stat: begin
`ifdef SPI_CMD_SLAVE_STATUS_EN
                  tx_d   = fcnt;
                  miso_d = fcnt[7];
`endif
                end
                default: begin
                  state_d = IGNORE;
                  oe_d    = 1'b0;
                end
              endcase
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            rx_d  = rx_nx;
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (wr) mem_d = rx_nx;
              done_d  = 1'b1;
              state_d = CMD;
              oe_d    = 1'b0;
              miso_d  = 1'b0;
            end
          // bit 7 is already on miso before the first data rise
          end else if (sclk_fall && cnt != 3'd0) begin
            miso_d = tx_sr[6];
            tx_d   = {tx_sr[6:0], 1'b0};
          end
        end
        IGNORE: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_sr     <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      mem_q      <= MEM_INIT;
      cmd_q      <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      wr         <= 1'b0;
      start      <= 1'b0;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cmd_sr     <= cmd_sr_d;
      rx_sr      <= rx_d;
      tx_sr      <= tx_d;
      mem_q      <= mem_d;
      cmd_q      <= cmdq_d;
      miso       <= miso_d;
      miso_oe    <= oe_d;
      wr         <= wr_d;
      start      <= start_d;
      done_pend  <= done_d;
      frame_done <= done_pend;
    end
  end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Bench for spi_cmd_slave: table-driven frames with a scoreboard queue,
// plus abort, ignore, host-load, reset and back-to-back sequences.
module tb_spi_cmd_slave;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] mem_q;
  logic       host_wr = 1'b0;
  logic [7:0] host_wdata = '0;
  logic       host_busy;
  logic       frame_done;
  logic [7:0] cmd_q;

  spi_cmd_slave dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .mem_q      (mem_q),
    .host_wr    (host_wr),
    .host_wdata (host_wdata),
    .host_busy  (host_busy),
    .frame_done (frame_done),
    .cmd_q      (cmd_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int wide = 0;
  logic fd_prev = 1'b0;

  always @(posedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_done && fd_prev) wide++;
    fd_prev = frame_done;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      #HALF;
      rx = {rx[6:0], miso};
      oe_all = oe_all & miso_oe;
      oe_any = oe_any | miso_oe;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    cs_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] exp_miso;
    logic [7:0] exp_mem;
  } vec_t;

  typedef struct {
    logic [7:0] miso;
    logic [7:0] mem;
    logic [7:0] cmd;
    int         done;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  initial begin
    logic [7:0] r;
    logic       oa;
    logic       oy;
    int         d0;
    exp_t       e;

    vecs[0] = '{8'h01, 8'h00, 8'hC8, 8'hC8};
    vecs[1] = '{8'h02, 8'h4D, 8'h00, 8'h4D};
    vecs[2] = '{8'h03, 8'hE1, 8'h4D, 8'hE1};
    vecs[3] = '{8'h01, 8'h00, 8'hE1, 8'hE1};
    vecs[4] = '{8'h03, 8'h00, 8'hE1, 8'h00};
    vecs[5] = '{8'h01, 8'h5A, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem", mem_q, 8'hC8);
    chk("rst_cmd", cmd_q, 8'h00);
    chk("rst_miso", miso, 1'b0);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_busy", host_busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      sb.push_back('{vecs[i].exp_miso, vecs[i].exp_mem, vecs[i].cmd, 1});
      d0 = done_cnt;
      cs_low();
      spi_bits(vecs[i].cmd, 8, r, oa, oy);
      spi_bits(vecs[i].data, 8, r, oa, oy);
      cs_high();
      e = sb.pop_front();
      chk($sformatf("v%0d_miso", i), r, e.miso);
      chk($sformatf("v%0d_mem", i), mem_q, e.mem);
      chk($sformatf("v%0d_cmd", i), cmd_q, e.cmd);
      chk($sformatf("v%0d_done", i), done_cnt - d0, e.done);
      chk($sformatf("v%0d_oe", i), oa, 1'b1);
    end

    d0 = done_cnt;
    cs_low();
    spi_bits(8'h02, 8, r, oa, oy);
    spi_bits(8'hFF, 4, r, oa, oy);
    cs_high();
    chk("part_mem", mem_q, 8'h00);
    chk("part_done", done_cnt - d0, 0);
    chk("part_oe", miso_oe, 1'b0);

    @(negedge clk);
    host_wdata = 8'h5A;
    host_wr = 1'b1;
    @(negedge clk);
    host_wr = 1'b0;
    @(negedge clk);
    chk("host_idle", mem_q, 8'h5A);

    d0 = done_cnt;
    cs_low();
    @(negedge clk);
    host_wdata = 8'h33;
    host_wr = 1'b1;
    @(negedge clk);
    host_wr = 1'b0;
    @(negedge clk);
    chk("host_busy", host_busy, 1'b1);
    chk("host_frame", mem_q, 8'h5A);
    spi_bits(8'h07, 8, r, oa, oy);
    spi_bits(8'hAA, 8, r, oa, oy);
    chk("ign_oe", oy, 1'b0);
    cs_high();
    chk("ign_mem", mem_q, 8'h5A);
    chk("ign_cmd", cmd_q, 8'h07);
    chk("ign_done", done_cnt - d0, 0);

    d0 = done_cnt;
    cs_low();
    spi_bits(8'h02, 8, r, oa, oy);
    spi_bits(8'hFF, 7, r, oa, oy);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_mem", mem_q, 8'hC8);
    chk("mrst_cmd", cmd_q, 8'h00);
    chk("mrst_oe", miso_oe, 1'b0);
    rst = 1'b0;
    spi_bits(8'hFF, 1, r, oa, oy);
    cs_high();
    chk("mrst_mem2", mem_q, 8'hC8);
    chk("mrst_done", done_cnt - d0, 0);

    do_reset();
    d0 = done_cnt;
    cs_low();
    spi_bits(8'h02, 8, r, oa, oy);
    spi_bits(8'h11, 8, r, oa, oy);
    spi_bits(8'h02, 8, r, oa, oy);
    spi_bits(8'h22, 8, r, oa, oy);
    spi_bits(8'h04, 8, r, oa, oy);
    spi_bits(8'h00, 8, r, oa, oy);
`ifdef SPI_CMD_SLAVE_STATUS_EN
    chk("stat_miso", r, 8'h02);
    chk("stat_oe", oa, 1'b1);
`else
    chk("stat_oe", oy, 1'b0);
`endif
    cs_high();
    chk("b2b_mem", mem_q, 8'h22);
    chk("b2b_cmd", cmd_q, 8'h04);
`ifdef SPI_CMD_SLAVE_STATUS_EN
    chk("b2b_done", done_cnt - d0, 3);
`else
    chk("b2b_done", done_cnt - d0, 2);
`endif
    chk("done_width", wide, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
